l2_mem_responder: RTL and testbench
===================================

L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, giving the number of word-index bits (2^DEPTH_LOG2 32-bit words).
REQ-002 SHALL have parameter RD_LAT, default 4, giving the read latency in cycles (legal range 1-15).
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have l2_mem_access_addr  input  32  byte address from the L1 initiator.
REQ-006 SHALL have l2_mem_wr_data  input  32  write data.
REQ-007 SHALL have l2_mem_en  input  1  request strobe.
REQ-008 SHALL have l2_mem_wr_en  input  1  write qualifier (1 = write, 0 = read) while l2_mem_en=1.
REQ-009 SHALL have l2_mem_rd_data  output  32  read response data.
REQ-010 SHALL have l2_mem_rd_vld  output  1  single-cycle pulse marking a valid l2_mem_rd_data.
REQ-011 SHALL have l2_mem_busy  output  1  request not accepted this cycle; the initiator holds the request stable.

Function
REQ-012 SHALL use word index = l2_mem_access_addr[DEPTH_LOG2+1:2]; upper address bits and bits [1:0] SHALL be ignored.
REQ-013 SHALL store data in a single-port array of 2^DEPTH_LOG2 x 32 bits, with at most one array access per cycle.
REQ-014 SHALL implement the FSM IDLE -> RD_WAIT -> IDLE; requests SHALL be accepted only in IDLE with l2_mem_busy=0.
REQ-015 SHALL accept a read in cycle T (en=1, wr_en=0, accepted) by sampling the read data source in T, then:
- enter RD_WAIT with a down-counter of RD_LAT-1;
- assert l2_mem_rd_vld for exactly one cycle at T+RD_LAT with l2_mem_rd_data valid.
REQ-016 SHALL hold l2_mem_rd_data stable after the pulse until the next read completes.
REQ-017 SHALL, for RD_LAT=1, stay in IDLE and pulse l2_mem_rd_vld in T+1.
REQ-018 SHALL drive l2_mem_busy=1 combinationally in RD_WAIT, except in the final RD_WAIT cycle, when a new request SHALL be accepted back-to-back.
REQ-019 SHALL post each accepted write (en=1, wr_en=1) into a one-entry write buffer (addr, data, wb_vld); writes SHALL never stall in IDLE.
REQ-020 SHALL drain the write buffer into the array in any cycle where wb_vld=1 and no read array access occurs, including the cycle a new write is loaded (old entry retired, new entry captured).
REQ-021 SHALL ignore l2_mem_wr_en when l2_mem_en=0 (no operation).
REQ-022 SHALL make requests presented while l2_mem_busy=1 have no side effect.

Reset
REQ-023 SHALL, on rst assertion, immediately set: state=IDLE, counter=0, wb_vld=0, l2_mem_rd_data=32'h0, l2_mem_rd_vld=0, l2_mem_busy=0.
REQ-024 SHALL abort a read in flight when rst asserts mid-operation, with no l2_mem_rd_vld pulse after rst deasserts and a pending buffered write discarded.
REQ-025 SHALL NOT reset array contents.

Configuration
REQ-026 SHALL support the macro L2_RESP_WR_FWD_EN.
REQ-027 SHALL, with L2_RESP_WR_FWD_EN defined, handle a read whose word index matches a valid write-buffer entry as follows:
- accept the read without stall;
- return the buffer data;
- perform no array read, so the buffer drains that cycle.
REQ-028 SHALL, with L2_RESP_WR_FWD_EN defined, serve a non-matching read from the array, with the buffer retained.
REQ-029 SHALL, without L2_RESP_WR_FWD_EN, when a read is requested while wb_vld=1:
- assert l2_mem_busy for one cycle while the buffer drains;
- accept the read the following cycle from the array.

Verification
REQ-030 SHALL cover (RD_LAT=4): write 0x1000<-0xDEADBEEF, idle 2 cycles, read 0x1000 at T -> l2_mem_rd_vld pulse at T+4 with data 0xDEADBEEF, busy high T+1..T+3.
REQ-031 SHALL cover: write 0x20<-0x11111111 immediately followed by read 0x20 -> with L2_RESP_WR_FWD_EN, no busy and data 0x11111111 at T+4; without it, one busy cycle, then data 0x11111111 at T+5.
REQ-032 SHALL cover: back-to-back reads of 0x0 and 0x4 -> the second is accepted in the first read's final RD_WAIT cycle, with two rd_vld pulses 4 cycles apart.
REQ-033 SHALL cover: five consecutive writes to 0x40..0x50, then reads of each -> all values returned, no busy during the writes.
REQ-034 SHALL cover: rst asserted 2 cycles after a read is accepted -> all outputs 0 within the reset cycle and no rd_vld pulse afterward.
REQ-035 SHALL cover: address 0xFFFF_C004 aliases with 0x4 (DEPTH_LOG2=12) -> a write to one is read back at the other.

Source files
------------

// File: rtl/l2_mem_responder_if.sv
// L1 -> L2 request/response bus for l2_mem_responder.
// The master drives requests and the slave returns read data, the valid pulse and busy.
interface l2_mem_responder_if;
  logic [31:0] l2_mem_access_addr;
  logic [31:0] l2_mem_wr_data;
  logic        l2_mem_en;
  logic        l2_mem_wr_en;
  logic [31:0] l2_mem_rd_data;
  logic        l2_mem_rd_vld;
  logic        l2_mem_busy;

  modport master (
    output l2_mem_access_addr, l2_mem_wr_data, l2_mem_en, l2_mem_wr_en,
    input  l2_mem_rd_data, l2_mem_rd_vld, l2_mem_busy
  );

  modport slave (
    input  l2_mem_access_addr, l2_mem_wr_data, l2_mem_en, l2_mem_wr_en,
    output l2_mem_rd_data, l2_mem_rd_vld, l2_mem_busy
  );
endinterface

// File: rtl/l2_mem_responder.sv
// Single-port L2 word memory with a posted one-entry write buffer and a fixed RD_LAT read latency.
// Define L2_RESP_WR_FWD_EN to forward write-buffer data to a matching read instead of stalling it.
module l2_mem_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 4
) (
  input logic               clk,
  input logic               rst,
  l2_mem_responder_if.slave bus
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);
  localparam bit         LAT_ONE  = (RD_LAT == 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t                state_r, state_nxt_s;
  logic [3:0]            cnt_r, cnt_nxt_s;
  logic [31:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_s, wb_addr_r;
  logic [31:0]           wb_data_r, rd_buf_r, rd_data_r, rd_src_s;
  logic                  wb_vld_r, rd_vld_r;
  logic                  rd_req_s, wait_busy_s, rd_conflict_s, busy_s;
  logic                  rd_acc_s, wr_acc_s, arr_rd_s, drain_s, fwd_hit_s, rd_done_s;
  logic                  unused_addr_s;

  assign idx_s         = bus.l2_mem_access_addr[DEPTH_LOG2+1:2];
  assign unused_addr_s = ^{bus.l2_mem_access_addr[31:DEPTH_LOG2+2], bus.l2_mem_access_addr[1:0]};
  assign rd_req_s      = bus.l2_mem_en && !bus.l2_mem_wr_en;

`ifdef L2_RESP_WR_FWD_EN
  assign fwd_hit_s     = wb_vld_r && (wb_addr_r == idx_s);
  assign rd_conflict_s = 1'b0;
`else
  // A read behind a pending write waits one cycle so the buffer can drain first.
  assign fwd_hit_s     = 1'b0;
  assign rd_conflict_s = rd_req_s && wb_vld_r;
`endif

  assign rd_src_s = fwd_hit_s ? wb_data_r : mem_r[idx_s];

  // State register and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; RD_WAIT with a zero count is the final wait cycle and accepts like IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (rd_acc_s && !LAT_ONE) begin
          state_nxt_s = RD_WAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      RD_WAIT: begin
        if (cnt_r != 4'd0) begin
          state_nxt_s = RD_WAIT;
          cnt_nxt_s   = cnt_r - 4'd1;
        end else if (rd_acc_s && !LAT_ONE) begin
          state_nxt_s = RD_WAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Output and handshake decode.
  always_comb begin
    case (state_r)
      IDLE:    wait_busy_s = 1'b0;
      RD_WAIT: wait_busy_s = (cnt_r != 4'd0);
      default: wait_busy_s = 1'b1;
    endcase
    busy_s    = wait_busy_s || rd_conflict_s;
    rd_acc_s  = rd_req_s && !busy_s;
    wr_acc_s  = bus.l2_mem_en && bus.l2_mem_wr_en && !busy_s;
    arr_rd_s  = rd_acc_s && !fwd_hit_s;
    drain_s   = wb_vld_r && !arr_rd_s;
    rd_done_s = (state_r == RD_WAIT) && (cnt_r == 4'd1);
  end

  // Read pipeline, response registers and write buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_r  <= 1'b0;
      rd_data_r <= 32'h0;
      rd_buf_r  <= 32'h0;
      wb_vld_r  <= 1'b0;
      wb_addr_r <= '0;
      wb_data_r <= 32'h0;
    end else begin
      rd_vld_r <= rd_done_s || (LAT_ONE && rd_acc_s);
      if (LAT_ONE && rd_acc_s) begin
        rd_data_r <= rd_src_s;
      end else if (rd_done_s) begin
        rd_data_r <= rd_buf_r;
      end
      if (rd_acc_s) begin
        rd_buf_r <= rd_src_s;
      end
      // A newly accepted write replaces the entry that drains into the array on the same edge.
      if (wr_acc_s) begin
        wb_vld_r  <= 1'b1;
        wb_addr_r <= idx_s;
        wb_data_r <= bus.l2_mem_wr_data;
      end else if (drain_s) begin
        wb_vld_r <= 1'b0;
      end
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (drain_s) begin
      mem_r[wb_addr_r] <= wb_data_r;
    end
  end

  assign bus.l2_mem_rd_data = rd_data_r;
  assign bus.l2_mem_rd_vld  = rd_vld_r;
  assign bus.l2_mem_busy    = busy_s;
endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed self-checking bench for l2_mem_responder (DEPTH_LOG2=12, RD_LAT=4).
module tb_l2_mem_responder;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  l2_mem_responder_if bus();

  l2_mem_responder #(.DEPTH_LOG2(12), .RD_LAT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output logic busy_seen);
    bus.l2_mem_en          = 1'b1;
    bus.l2_mem_wr_en       = 1'b1;
    bus.l2_mem_access_addr = a;
    bus.l2_mem_wr_data     = d;
    #1 busy_seen = bus.l2_mem_busy;
    @(negedge clk);
    bus.l2_mem_en    = 1'b0;
    bus.l2_mem_wr_en = 1'b0;
  endtask

  // Holds a read until accepted, then reports stall cycles, cycles to rd_vld after acceptance, and data.
  task automatic do_read(input logic [31:0] a, output int stall, output int lat, output logic [31:0] data);
    bus.l2_mem_en          = 1'b1;
    bus.l2_mem_wr_en       = 1'b0;
    bus.l2_mem_access_addr = a;
    stall = 0;
    lat   = 0;
    data  = 32'h0;
    #1;
    while (bus.l2_mem_busy === 1'b1 && stall < 16) begin
      @(negedge clk);
      #1;
      stall++;
    end
    @(negedge clk);
    bus.l2_mem_en = 1'b0;
    #1;
    for (int k = 1; k <= 20; k++) begin
      if (bus.l2_mem_rd_vld === 1'b1) begin
        lat  = k;
        data = bus.l2_mem_rd_data;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.l2_mem_rd_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b expected 0", bus.l2_mem_rd_vld); end
    checks++;
    if (bus.l2_mem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.l2_mem_busy); end
    checks++;
    if (bus.l2_mem_rd_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", bus.l2_mem_rd_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_read();
    logic b;
    logic exp_busy;
    logic exp_vld;
    do_write(32'h0000_1000, 32'hDEAD_BEEF, b);
    checks++;
    if (b !== 1'b0) begin failures++; $display("FAIL basic_wr_busy: got %b expected 0", b); end
    idle(2);
    bus.l2_mem_en          = 1'b1;
    bus.l2_mem_wr_en       = 1'b0;
    bus.l2_mem_access_addr = 32'h0000_1000;
    #1;
    checks++;
    if (bus.l2_mem_busy !== 1'b0) begin failures++; $display("FAIL basic_accept_busy: got %b expected 0", bus.l2_mem_busy); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.l2_mem_en = 1'b0;
      #1;
      exp_busy = (k <= 3);
      exp_vld  = (k == 4);
      checks++;
      if (bus.l2_mem_busy !== exp_busy) begin failures++; $display("FAIL basic_busy T+%0d: got %b expected %b", k, bus.l2_mem_busy, exp_busy); end
      checks++;
      if (bus.l2_mem_rd_vld !== exp_vld) begin failures++; $display("FAIL basic_vld T+%0d: got %b expected %b", k, bus.l2_mem_rd_vld, exp_vld); end
      if (k >= 4) begin
        checks++;
        if (bus.l2_mem_rd_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_data T+%0d: got %h expected deadbeef", k, bus.l2_mem_rd_data); end
      end
    end
    idle(3);
    checks++;
    if (bus.l2_mem_rd_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_data_hold: got %h expected deadbeef", bus.l2_mem_rd_data); end
  endtask

  task automatic test_write_then_read();
    logic        b;
    int          stall;
    int          lat;
    logic [31:0] data;
    int          exp_stall;
`ifdef L2_RESP_WR_FWD_EN
    exp_stall = 0;
`else
    exp_stall = 1;
`endif
    do_write(32'h0000_0020, 32'h1111_1111, b);
    do_read(32'h0000_0020, stall, lat, data);
    checks++;
    if (stall !== exp_stall) begin failures++; $display("FAIL wr_rd_stall: got %0d expected %0d", stall, exp_stall); end
    checks++;
    if (stall + lat !== 4 + exp_stall) begin failures++; $display("FAIL wr_rd_latency: got %0d expected %0d", stall + lat, 4 + exp_stall); end
    checks++;
    if (data !== 32'h1111_1111) begin failures++; $display("FAIL wr_rd_data: got %h expected 11111111", data); end
  endtask

  task automatic test_back_to_back();
    logic b;
    logic exp_busy;
    logic exp_vld;
    do_write(32'h0000_0000, 32'hA5A5_0000, b);
    do_write(32'h0000_0004, 32'h5A5A_0004, b);
    idle(2);
    bus.l2_mem_en          = 1'b1;
    bus.l2_mem_wr_en       = 1'b0;
    bus.l2_mem_access_addr = 32'h0000_0000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.l2_mem_access_addr = 32'h0000_0004;
      if (k == 5) bus.l2_mem_en = 1'b0;
      #1;
      exp_busy = (k != 4) && (k != 8);
      exp_vld  = (k == 4) || (k == 8);
      checks++;
      if (bus.l2_mem_busy !== exp_busy) begin failures++; $display("FAIL b2b_busy T+%0d: got %b expected %b", k, bus.l2_mem_busy, exp_busy); end
      checks++;
      if (bus.l2_mem_rd_vld !== exp_vld) begin failures++; $display("FAIL b2b_vld T+%0d: got %b expected %b", k, bus.l2_mem_rd_vld, exp_vld); end
      if (k == 4) begin
        checks++;
        if (bus.l2_mem_rd_data !== 32'hA5A5_0000) begin failures++; $display("FAIL b2b_data1: got %h expected a5a50000", bus.l2_mem_rd_data); end
      end
      if (k == 8) begin
        checks++;
        if (bus.l2_mem_rd_data !== 32'h5A5A_0004) begin failures++; $display("FAIL b2b_data2: got %h expected 5a5a0004", bus.l2_mem_rd_data); end
      end
    end
  endtask

  task automatic test_write_burst();
    logic        b;
    int          stall;
    int          lat;
    logic [31:0] data;
    for (int i = 0; i < 5; i++) begin
      do_write(32'h0000_0040 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), b);
      checks++;
      if (b !== 1'b0) begin failures++; $display("FAIL burst_wr_busy %0d: got %b expected 0", i, b); end
    end
    idle(1);
    for (int i = 0; i < 5; i++) begin
      do_read(32'h0000_0040 + 32'(4 * i), stall, lat, data);
      checks++;
      if (data !== 32'hC0DE_0000 + 32'(i)) begin failures++; $display("FAIL burst_rd_data %0d: got %h expected %h", i, data, 32'hC0DE_0000 + 32'(i)); end
      checks++;
      if (stall + lat !== 4) begin failures++; $display("FAIL burst_rd_latency %0d: got %0d expected 4", i, stall + lat); end
    end
  endtask

  task automatic test_alias();
    logic        b;
    int          stall;
    int          lat;
    logic [31:0] data;
    do_write(32'hFFFF_C004, 32'h600D_F00D, b);
    idle(1);
    do_read(32'h0000_0004, stall, lat, data);
    checks++;
    if (data !== 32'h600D_F00D) begin failures++; $display("FAIL alias_hi_to_lo: got %h expected 600df00d", data); end
    do_write(32'h0000_0004, 32'h1234_5678, b);
    idle(1);
    do_read(32'hFFFF_C004, stall, lat, data);
    checks++;
    if (data !== 32'h1234_5678) begin failures++; $display("FAIL alias_lo_to_hi: got %h expected 12345678", data); end
  endtask

  task automatic test_noop();
    int          stall;
    int          lat;
    logic [31:0] data;
    bus.l2_mem_en          = 1'b0;
    bus.l2_mem_wr_en       = 1'b1;
    bus.l2_mem_access_addr = 32'h0000_1000;
    bus.l2_mem_wr_data     = 32'h0000_0000;
    idle(3);
    bus.l2_mem_wr_en = 1'b0;
    do_read(32'h0000_1000, stall, lat, data);
    checks++;
    if (data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL noop_wr_ignored: got %h expected deadbeef", data); end
  endtask

  task automatic test_reset_mid();
    logic        b;
    int          pulses;
    int          stall;
    int          lat;
    logic [31:0] data;
    idle(1);
    bus.l2_mem_en          = 1'b1;
    bus.l2_mem_wr_en       = 1'b0;
    bus.l2_mem_access_addr = 32'h0000_0040;
    @(negedge clk);
    bus.l2_mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.l2_mem_rd_vld !== 1'b0) begin failures++; $display("FAIL midrst_vld: got %b expected 0", bus.l2_mem_rd_vld); end
    checks++;
    if (bus.l2_mem_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bus.l2_mem_busy); end
    checks++;
    if (bus.l2_mem_rd_data !== 32'h0) begin failures++; $display("FAIL midrst_data: got %h expected 0", bus.l2_mem_rd_data); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.l2_mem_rd_vld === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulses); end
    // A buffered write caught by reset must never reach the array.
    do_write(32'h0000_1000, 32'hBAD0_BAD0, b);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(32'h0000_1000, stall, lat, data);
    checks++;
    if (data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL midrst_wb_discard: got %h expected deadbeef", data); end
  endtask

  initial begin
    checks                 = 0;
    failures               = 0;
    rst                    = 1'b0;
    bus.l2_mem_en          = 1'b0;
    bus.l2_mem_wr_en       = 1'b0;
    bus.l2_mem_access_addr = 32'h0;
    bus.l2_mem_wr_data     = 32'h0;
    test_reset();
    test_basic_read();
    test_write_then_read();
    test_back_to_back();
    test_write_burst();
    test_alias();
    test_noop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
